// File: rtl/bit_seq_ctrl_pkg.sv
// Shared types and constants for the step-pattern sequencer: FSM state
// encoding, default geometry and the six-step power-on pattern table.
package bit_seq_pkg;

   localparam int DEF_OUT_W     = 8;
   localparam int DEF_MAX_STEPS = 8;
   localparam int DEF_DIV_W     = 16;
   localparam int DEF_DEAD_W    = 4;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DEAD = 2'd2
   } state_e;

   // Six-step commutation patterns; unused tail entries stay dark.
   localparam logic [7:0] DEFAULT_TABLE [DEF_MAX_STEPS] = '{
      8'h90, 8'h18, 8'h48, 8'h60, 8'h24, 8'h84, 8'h00, 8'h00
   };

   function automatic logic [7:0] default_entry(input int idx);
      logic [7:0] v;
      v = 8'h00;
      for (int i = 0; i < DEF_MAX_STEPS; i++) begin
         if (i == idx) v = DEFAULT_TABLE[i];
      end
      return v;
   endfunction

endpackage

// File: rtl/bit_seq_ctrl_if.sv
// Configuration, table-write and status bundle between the pin wrapper
// (master) and the sequencer (slave).
interface bit_seq_ctrl_if #(
   parameter int OUT_W     = bit_seq_pkg::DEF_OUT_W,
   parameter int MAX_STEPS = bit_seq_pkg::DEF_MAX_STEPS,
   parameter int DIV_W     = bit_seq_pkg::DEF_DIV_W,
   parameter int DEAD_W    = bit_seq_pkg::DEF_DEAD_W
) ();

   localparam int IDX_W = $clog2(MAX_STEPS);

   logic              en;
   logic              dir;
   logic [DIV_W-1:0]  div;
   logic [DEAD_W-1:0] dead;
   logic [IDX_W-1:0]  last_idx;
   logic              wr_en;
   logic [IDX_W-1:0]  wr_addr;
   logic [OUT_W-1:0]  wr_data;
   logic [OUT_W-1:0]  out;
   logic [IDX_W-1:0]  step_idx;
   logic              step_pulse;
   logic              busy;

   modport master (
      output en, dir, div, dead, last_idx, wr_en, wr_addr, wr_data,
      input  out, step_idx, step_pulse, busy
   );

   modport slave (
      input  en, dir, div, dead, last_idx, wr_en, wr_addr, wr_data,
      output out, step_idx, step_pulse, busy
   );

endinterface

// File: rtl/bit_seq_ctrl_table.sv
// Pattern register file: one synchronous write port, one combinational read
// port with write-through so a same-cycle write is visible to the reader.
module bit_seq_table
   import bit_seq_pkg::*;
#(
   parameter int OUT_W     = DEF_OUT_W,
   parameter int MAX_STEPS = DEF_MAX_STEPS,
   localparam int IDX_W    = $clog2(MAX_STEPS)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             wr_en,
   input  logic [IDX_W-1:0] wr_addr,
   input  logic [OUT_W-1:0] wr_data,
   input  logic [IDX_W-1:0] rd_addr,
   output logic [OUT_W-1:0] rd_data
);

   logic [OUT_W-1:0] tbl_q [MAX_STEPS];
   logic [OUT_W-1:0] tbl_d [MAX_STEPS];

   always_comb begin
      tbl_d = tbl_q;
      if (wr_en) tbl_d[wr_addr] = wr_data;
   end

   assign rd_data = tbl_d[rd_addr];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < MAX_STEPS; i++) begin
            tbl_q[i] <= OUT_W'(default_entry(i));
         end
      end else begin
         tbl_q <= tbl_d;
      end
   end

endmodule

// File: rtl/bit_seq_ctrl.sv
// Step-pattern sequencer: walks table entries 0..last_idx at div+1 cycles per
// step, optional dead-time blanking between steps, 1-cycle enable latency.
module bit_seq_ctrl
   import bit_seq_pkg::*;
#(
   parameter int OUT_W     = DEF_OUT_W,
   parameter int MAX_STEPS = DEF_MAX_STEPS,
   parameter int DIV_W     = DEF_DIV_W,
   parameter int DEAD_W    = DEF_DEAD_W
) (
   input  logic          clk,
   input  logic          rst_n,
   bit_seq_ctrl_if.slave bus
);

   localparam int IDX_W = $clog2(MAX_STEPS);

   state_e            state_q, state_d;
   logic [DIV_W-1:0]  pc_q, pc_d;
   logic [DEAD_W-1:0] dc_q, dc_d;
   logic [IDX_W-1:0]  idx_q, idx_d;
   logic [OUT_W-1:0]  out_q, out_d;
   logic              pulse_q, pulse_d;

   logic              at_wrap;
   logic [IDX_W-1:0]  nxt_idx;
   logic [IDX_W-1:0]  rd_addr;
   logic [OUT_W-1:0]  rd_data;

   // Out-of-range indices (after last_idx shrinks) fold back on the next advance.
   function automatic logic [IDX_W-1:0] next_index(input logic [IDX_W-1:0] idx,
                                                   input logic [IDX_W-1:0] last,
                                                   input logic             rev);
      if (!rev) return (idx >= last) ? '0 : idx + IDX_W'(1);
      return (idx == '0 || idx > last) ? last : idx - IDX_W'(1);
   endfunction

   assign at_wrap = (pc_q == bus.div);
   assign nxt_idx = next_index(idx_q, bus.last_idx, bus.dir);
   assign rd_addr = (state_q == ST_RUN && at_wrap) ? nxt_idx : idx_q;

   bit_seq_table #(
      .OUT_W     (OUT_W),
      .MAX_STEPS (MAX_STEPS)
   ) u_table (
      .clk     (clk),
      .rst_n   (rst_n),
      .wr_en   (bus.wr_en),
      .wr_addr (bus.wr_addr),
      .wr_data (bus.wr_data),
      .rd_addr (rd_addr),
      .rd_data (rd_data)
   );

   always_comb begin
      state_d = state_q;
      pc_d    = pc_q;
      dc_d    = dc_q;
      idx_d   = idx_q;
      out_d   = out_q;
      pulse_d = 1'b0;

      if (!bus.en) begin
         state_d = ST_IDLE;
         out_d   = '0;
         pc_d    = '0;
         dc_d    = '0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               out_d   = rd_data;
               pc_d    = '0;
               state_d = ST_RUN;
            end
            ST_RUN: begin
               // Re-reading every cycle lets table writes reach the pins at once.
               pc_d  = pc_q + DIV_W'(1);
               out_d = rd_data;
               if (at_wrap) begin
                  pc_d    = '0;
                  pulse_d = 1'b1;
                  idx_d   = nxt_idx;
                  if (bus.dead != '0) begin
                     out_d   = '0;
                     dc_d    = bus.dead;
                     state_d = ST_DEAD;
                  end
               end
            end
            ST_DEAD: begin
               out_d = '0;
               pc_d  = '0;
               dc_d  = dc_q - DEAD_W'(1);
               if (dc_q <= DEAD_W'(1)) begin
                  out_d   = rd_data;
                  dc_d    = '0;
                  state_d = ST_RUN;
               end
            end
            default: begin
               out_d   = '0;
               state_d = ST_IDLE;
            end
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
         pc_q    <= '0;
         dc_q    <= '0;
         idx_q   <= '0;
         out_q   <= '0;
         pulse_q <= 1'b0;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         dc_q    <= dc_d;
         idx_q   <= idx_d;
         out_q   <= out_d;
         pulse_q <= pulse_d;
      end
   end

   assign bus.out        = out_q;
   assign bus.step_idx   = idx_q;
   assign bus.step_pulse = pulse_q;
   assign bus.busy       = (state_q != ST_IDLE);

endmodule

// File: tb/tb_bit_seq_ctrl.sv
// Directed bench for bit_seq_ctrl: checkpoint table for the basic run modes,
// then hand-written sequences for writes, index shrink, enable drop and reset.
module tb_bit_seq_ctrl;

   logic clk;
   logic rst_n;

   bit_seq_ctrl_if bus ();

   bit_seq_ctrl u_dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic        en;
      logic        dir;
      logic [15:0] div;
      logic [3:0]  dead;
      logic [2:0]  last;
      int          ncyc;
      logic [7:0]  e_out;
      logic [2:0]  e_idx;
      logic        e_pulse;
      logic        e_busy;
   } vec_t;

   vec_t vecs [$];
   int   n_checks = 0;
   int   n_err    = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic add(input logic en, input logic dir, input logic [15:0] div,
                      input logic [3:0] dead, input logic [2:0] last, input int ncyc,
                      input logic [7:0] e_out, input logic [2:0] e_idx,
                      input logic e_pulse, input logic e_busy);
      vec_t v;
      v.en = en; v.dir = dir; v.div = div; v.dead = dead; v.last = last;
      v.ncyc = ncyc; v.e_out = e_out; v.e_idx = e_idx;
      v.e_pulse = e_pulse; v.e_busy = e_busy;
      vecs.push_back(v);
   endtask

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   // Steps until cond_sel is met or the budget runs out; reports whether it was met.
   task automatic wait_for(input int sel, input logic [2:0] idx, input int budget,
                           output logic found);
      found = 1'b0;
      for (int c = 0; c < budget && !found; c++) begin
         tick(1);
         if (sel == 0 && bus.step_idx == idx) found = 1'b1;
         if (sel == 1 && bus.step_pulse) found = 1'b1;
         if (sel == 2 && bus.step_pulse && bus.step_idx == idx) found = 1'b1;
      end
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic found;

      rst_n        = 1'b0;
      bus.en       = 1'b0;
      bus.dir      = 1'b0;
      bus.div      = 16'd3;
      bus.dead     = 4'd0;
      bus.last_idx = 3'd5;
      bus.wr_en    = 1'b0;
      bus.wr_addr  = 3'd0;
      bus.wr_data  = 8'h00;

      // Forward run, div=3: each pattern held 4 cycles, wrap after index 5.
      add(1, 0, 3, 0, 5, 1, 8'h90, 0, 0, 1);
      add(1, 0, 3, 0, 5, 3, 8'h90, 0, 0, 1);
      add(1, 0, 3, 0, 5, 1, 8'h18, 1, 1, 1);
      add(1, 0, 3, 0, 5, 1, 8'h18, 1, 0, 1);
      add(1, 0, 3, 0, 5, 3, 8'h48, 2, 1, 1);
      add(1, 0, 3, 0, 5, 4, 8'h60, 3, 1, 1);
      add(1, 0, 3, 0, 5, 4, 8'h24, 4, 1, 1);
      add(1, 0, 3, 0, 5, 4, 8'h84, 5, 1, 1);
      add(1, 0, 3, 0, 5, 4, 8'h90, 0, 1, 1);
      add(1, 0, 3, 0, 5, 3, 8'h90, 0, 0, 1);
      // Reverse from index 0 goes to last_idx first.
      add(1, 1, 3, 0, 5, 1, 8'h84, 5, 1, 1);
      add(1, 1, 3, 0, 5, 4, 8'h24, 4, 1, 1);
      add(1, 1, 3, 0, 5, 4, 8'h60, 3, 1, 1);
      add(1, 1, 3, 0, 5, 4, 8'h48, 2, 1, 1);
      add(1, 1, 3, 0, 5, 4, 8'h18, 1, 1, 1);
      add(1, 1, 3, 0, 5, 4, 8'h90, 0, 1, 1);
      add(0, 0, 3, 0, 5, 1, 8'h00, 0, 0, 0);
      // Dead time 2: two blank cycles between patterns, period 6.
      add(1, 0, 3, 2, 5, 1, 8'h90, 0, 0, 1);
      add(1, 0, 3, 2, 5, 3, 8'h90, 0, 0, 1);
      add(1, 0, 3, 2, 5, 1, 8'h00, 1, 1, 1);
      add(1, 0, 3, 2, 5, 1, 8'h00, 1, 0, 1);
      add(1, 0, 3, 2, 5, 1, 8'h18, 1, 0, 1);
      add(1, 0, 3, 2, 5, 3, 8'h18, 1, 0, 1);
      add(1, 0, 3, 2, 5, 1, 8'h00, 2, 1, 1);
      add(1, 0, 3, 2, 5, 2, 8'h48, 2, 0, 1);

      tick(1);
      chk("rst.out",   32'(bus.out),        32'h00);
      chk("rst.idx",   32'(bus.step_idx),   32'd0);
      chk("rst.pulse", 32'(bus.step_pulse), 32'd0);
      chk("rst.busy",  32'(bus.busy),       32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      #1;

      for (int i = 0; i < vecs.size(); i++) begin
         bus.en       = vecs[i].en;
         bus.dir      = vecs[i].dir;
         bus.div      = vecs[i].div;
         bus.dead     = vecs[i].dead;
         bus.last_idx = vecs[i].last;
         tick(vecs[i].ncyc);
         chk($sformatf("v%0d.out", i),   32'(bus.out),        32'(vecs[i].e_out));
         chk($sformatf("v%0d.idx", i),   32'(bus.step_idx),   32'(vecs[i].e_idx));
         chk($sformatf("v%0d.pulse", i), 32'(bus.step_pulse), 32'(vecs[i].e_pulse));
         chk($sformatf("v%0d.busy", i),  32'(bus.busy),       32'(vecs[i].e_busy));
      end

      // Write the entry on display: visible on the very next edge.
      bus.wr_en = 1'b1; bus.wr_addr = 3'd2; bus.wr_data = 8'hFF;
      tick(1);
      chk("wr.next", 32'(bus.out), 32'hFF);
      bus.wr_en = 1'b0;
      tick(1);
      chk("wr.hold", 32'(bus.out), 32'hFF);

      // Enable drop keeps the index; re-enable resumes on the same entry.
      bus.en = 1'b0;
      tick(1);
      chk("dis.out",  32'(bus.out),      32'h00);
      chk("dis.busy", 32'(bus.busy),     32'd0);
      chk("dis.idx",  32'(bus.step_idx), 32'd2);
      bus.dead = 4'd0; bus.en = 1'b1;
      tick(1);
      chk("resume.out", 32'(bus.out),      32'hFF);
      chk("resume.idx", 32'(bus.step_idx), 32'd2);

      // Shrink last_idx below the current index: next advance wraps to 0.
      wait_for(0, 3'd4, 40, found);
      chk("wait.idx4", 32'(found), 32'd1);
      chk("idx4.out",  32'(bus.out), 32'h24);
      bus.last_idx = 3'd2;
      wait_for(1, 3'd0, 40, found);
      chk("wait.shrink", 32'(found), 32'd1);
      chk("shrink.idx",  32'(bus.step_idx), 32'd0);
      chk("shrink.out",  32'(bus.out),      32'h90);

      // Drop enable while blanked at index 3, then resume on table[3].
      bus.last_idx = 3'd5; bus.dead = 4'd3; bus.div = 16'd1;
      wait_for(2, 3'd3, 80, found);
      chk("wait.idx3",  32'(found),    32'd1);
      chk("dead3.out",  32'(bus.out),  32'h00);
      chk("dead3.busy", 32'(bus.busy), 32'd1);
      bus.en = 1'b0;
      tick(1);
      chk("deaddis.out",  32'(bus.out),      32'h00);
      chk("deaddis.busy", 32'(bus.busy),     32'd0);
      chk("deaddis.idx",  32'(bus.step_idx), 32'd3);
      bus.en = 1'b1;
      tick(1);
      chk("deadres.out",  32'(bus.out),  32'h60);
      chk("deadres.busy", 32'(bus.busy), 32'd1);

      // Corrupt entry 0, then async reset mid-run must restore everything.
      bus.wr_en = 1'b1; bus.wr_addr = 3'd0; bus.wr_data = 8'h11;
      tick(1);
      bus.wr_en = 1'b0;
      tick(2);
      #2;
      rst_n = 1'b0;
      #1;
      chk("arst.out",   32'(bus.out),        32'h00);
      chk("arst.idx",   32'(bus.step_idx),   32'd0);
      chk("arst.pulse", 32'(bus.step_pulse), 32'd0);
      chk("arst.busy",  32'(bus.busy),       32'd0);
      @(negedge clk);
      rst_n = 1'b1; bus.dead = 4'd0; bus.div = 16'd0;
      tick(1);
      chk("post.out", 32'(bus.out),      32'h90);
      chk("post.idx", 32'(bus.step_idx), 32'd0);

      // div=0 with no dead time changes pattern every cycle.
      tick(1);
      chk("div0.out1",   32'(bus.out),        32'h18);
      chk("div0.pulse1", 32'(bus.step_pulse), 32'd1);
      tick(1);
      chk("div0.out2",   32'(bus.out),        32'h48);
      chk("div0.idx2",   32'(bus.step_idx),   32'd2);

      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end

endmodule
